hamming_secded_decoder: RTL and testbench

- Parametrised, pipelined Hamming decoder with an optional SECDED mode, for the same Hamming link/storage path as the team's existing 12-bit combinational decoder.
- Accepts codewords over a valid/ready handshake and corrects single-bit errors.
- In SECDED mode it also detects double-bit errors.
- Outputs the extracted data bits with error flags and keeps saturating error counters for status readout.

---
 rtl/hamming_secded_decoder.sv | 199 +++++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamming_secded_decoder
// Description : Pipelined Hamming decoder with optional SECDED mode.
//               Two elastic register stages: S1 holds the codeword payload,
//               syndrome and overall parity; S2 holds the corrected data and
//               error flags. Saturating counters track corrected and
//               uncorrectable words as they leave the block.
// Ports       : Clk, Reset          - clock, asynchronous active-high reset
//               in_valid/in_ready   - codeword input handshake
//               in_word[CW-1:0]     - codeword, bit i = Hamming position i+1,
//                                     bit CW-1 = overall parity when SECDED=1
//               out_valid/out_ready - decoded output handshake
//               out_data            - extracted data bits
//               out_corrected       - single-bit error corrected
//               out_uncorrectable   - double error or syndrome out of range
//               corr_count          - saturating count of corrected words
//               uncorr_count        - saturating count of uncorrectable words
//               clear_counts        - synchronous clear of both counters
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_secded_decoder #(
    parameter int DATA_W = 12,
    parameter int SECDED = 1,
    parameter int CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1.
    localparam int R  = (DATA_W <= 1)   ? 2 :
                        (DATA_W <= 4)   ? 3 :
                        (DATA_W <= 11)  ? 4 :
                        (DATA_W <= 26)  ? 5 :
                        (DATA_W <= 57)  ? 6 :
                        (DATA_W <= 120) ? 7 :
                        (DATA_W <= 247) ? 8 :
                        (DATA_W <= 502) ? 9 : 10,
    localparam int CW = DATA_W + R + SECDED
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    input  logic              clear_counts
);

    // Number of Hamming positions (data + parity, excluding overall parity).
    localparam int N = DATA_W + R;

    // Hamming position (1-based) of data bit d: d-th non-power-of-two position.
    function automatic int data_pos(input int d);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic [R-1:0]      syn_in;
    logic              par_in;
    logic              ready_en;
    logic              s1_valid;
    logic [N-1:0]      s1_data;
    logic [R-1:0]      s1_syn;
    logic              s1_par;
    logic              s1_move;
    logic              in_fire;
    logic              out_fire;
    logic              syn_nz;
    logic              in_range;
    logic              flip;
    logic              dec_corr;
    logic              dec_unc;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] dec_data;

    // ------------------------------------------------------------------
    // Handshake: a stage loads when its successor is empty or draining.
    // ready_en holds in_ready low for the first cycle after reset.
    // ------------------------------------------------------------------
    assign out_fire = out_valid & out_ready;
    assign s1_move  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ready_en & (~s1_valid | s1_move);
    assign in_fire  = in_valid & in_ready;

    // Syndrome bit k covers every position with bit k set.
    always_comb begin
        syn_in = '0;
        for (int k = 0; k < R; k++) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) >> k) & 1) != 0) syn_in[k] = syn_in[k] ^ in_word[i];
            end
        end
    end

    assign par_in = ^in_word;

    // ------------------------------------------------------------------
    // Stage 1: payload, syndrome, overall parity
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= in_word[N-1:0];
                s1_syn   <= syn_in;
                s1_par   <= par_in;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode classification
    // ------------------------------------------------------------------
    assign syn_nz   = |s1_syn;
    assign in_range = syn_nz & (s1_syn <= R'(N));

    if (SECDED != 0) begin : g_secded
        // P=1 means an odd number of flips: single error (or overall bit).
        assign flip     = s1_par & in_range;
        assign dec_corr = s1_par & (~syn_nz | in_range);
        assign dec_unc  = syn_nz & (~s1_par | ~in_range);
    end else begin : g_hamming
        assign flip     = in_range;
        assign dec_corr = in_range;
        assign dec_unc  = syn_nz & ~in_range;
    end

    always_comb begin
        fixed = '0;
        for (int i = 0; i < N; i++) begin
            fixed[i] = s1_data[i] ^ (flip && (s1_syn == R'(i + 1)));
        end
    end

    for (genvar d = 0; d < DATA_W; d++) begin : g_extract
        localparam int POS = data_pos(d);
        assign dec_data[d] = fixed[POS-1];
    end

    // ------------------------------------------------------------------
    // Stage 2: registered outputs, held while stalled
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else if (s1_move) begin
            out_valid         <= 1'b1;
            out_data          <= dec_data;
            out_corrected     <= dec_corr;
            out_uncorrectable <= dec_unc;
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counters; clear has priority over increment.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (clear_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_fire) begin
            if (out_corrected && (corr_count != '1))
                corr_count <= corr_count + 1'b1;
            if (out_uncorrectable && (uncorr_count != '1))
                uncorr_count <= uncorr_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_secded_decoder
// Description : Self-checking bench for hamming_secded_decoder. Three
//               instances: defaults, SECDED=0, and CNT_W=2. Expected values
//               come from a positional Hamming reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_decoder;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        unc;
    } res_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic Reset;

    // default instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        out_corrected, out_uncorrectable, clear_counts;
    logic [17:0] in_word;
    logic [11:0] out_data;
    logic [15:0] corr_count, uncorr_count;

    // SECDED=0 instance
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic        h_corr, h_unc, h_clear;
    logic [16:0] h_in_word;
    logic [11:0] h_out_data;
    logic [15:0] h_cc, h_uc;

    // CNT_W=2 instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic        c_corr, c_unc, c_clear;
    logic [17:0] c_in_word;
    logic [11:0] c_out_data;
    logic [1:0]  c_cc, c_uc;

    hamming_secded_decoder dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
        .corr_count(corr_count), .uncorr_count(uncorr_count),
        .clear_counts(clear_counts)
    );

    hamming_secded_decoder #(.SECDED(0)) dut_h (
        .Clk(Clk), .Reset(Reset),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_word(h_in_word),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
        .out_corrected(h_corr), .out_uncorrectable(h_unc),
        .corr_count(h_cc), .uncorr_count(h_uc),
        .clear_counts(h_clear)
    );

    hamming_secded_decoder #(.CNT_W(2)) dut_c (
        .Clk(Clk), .Reset(Reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_word(c_in_word),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_corrected(c_corr), .out_uncorrectable(c_unc),
        .corr_count(c_cc), .uncorr_count(c_uc),
        .clear_counts(c_clear)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int calc_r(input int dw);
        int r;
        r = 0;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    function automatic logic [31:0] encode(input int dw, input int sec, input logic [31:0] data);
        logic [31:0] w;
        int n, d, syn;
        n = dw + calc_r(dw);
        w = '0;
        d = 0;
        syn = 0;
        for (int p = 1; p <= n; p++)
            if ((p & (p - 1)) != 0) begin w[p-1] = data[d]; d++; end
        // XOR of the positions of set data bits tells which parity bits to set
        for (int p = 1; p <= n; p++) if (w[p-1]) syn = syn ^ p;
        for (int p = 1; p <= n; p++)
            if (((p & (p - 1)) == 0) && ((syn & p) != 0)) w[p-1] = 1'b1;
        if (sec != 0) w[n] = ^w;
        return w;
    endfunction

    function automatic res_t decode(input int dw, input int sec, input logic [31:0] w);
        res_t r;
        int n, syn, d;
        logic par;
        n = dw + calc_r(dw);
        r = '0;
        syn = 0;
        par = 1'b0;
        for (int p = 1; p <= n; p++) if (w[p-1]) syn = syn ^ p;
        for (int b = 0; b < n + sec; b++) par = par ^ w[b];
        if (sec != 0) begin
            if (syn == 0) r.corr = par;
            else if (!par || syn > n) r.unc = 1'b1;
            else begin w[syn-1] = ~w[syn-1]; r.corr = 1'b1; end
        end else begin
            if (syn > n) r.unc = 1'b1;
            else if (syn != 0) begin w[syn-1] = ~w[syn-1]; r.corr = 1'b1; end
        end
        d = 0;
        for (int p = 1; p <= n; p++)
            if ((p & (p - 1)) != 0) begin r.data[d] = w[p-1]; d++; end
        return r;
    endfunction

    function automatic logic [17:0] rand_word();
        logic [31:0] w;
        int a, b;
        w = encode(12, 1, $urandom);
        a = $urandom_range(0, 17);
        b = (a + $urandom_range(1, 17)) % 18;
        case ($urandom % 8)
            0:       w = $urandom;
            1, 2:    w[a] = ~w[a];
            3, 4:    begin w[a] = ~w[a]; w[b] = ~w[b]; end
            default: ;
        endcase
        return w[17:0];
    endfunction

    // ---------------- scoreboard for default instance ----------------
    res_t        exp_q[$];
    res_t        mon_e;
    int          out_cnt = 0;
    logic [15:0] exp_cc = '0, exp_uc = '0;
    logic [11:0] last_data;
    logic        last_corr, last_unc;
    logic        hold_v = 1'b0;
    logic [13:0] hold_d;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {out_corrected, out_uncorrectable, out_data}, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = {out_corrected, out_uncorrectable, out_data};
            if (out_valid && out_ready) begin
                chk("corr_count", corr_count, exp_cc);
                chk("uncorr_count", uncorr_count, exp_uc);
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data", out_data, mon_e.data[11:0]);
                    chk("corr", out_corrected, mon_e.corr);
                    chk("unc", out_uncorrectable, mon_e.unc);
                    if (mon_e.corr && exp_cc != 16'hFFFF) exp_cc++;
                    if (mon_e.unc && exp_uc != 16'hFFFF) exp_uc++;
                end
                last_data = out_data;
                last_corr = out_corrected;
                last_unc  = out_uncorrectable;
                out_cnt++;
            end
            if (in_valid && in_ready) exp_q.push_back(decode(12, 1, {14'b0, in_word}));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [17:0] w);
        in_valid = 1'b1;
        in_word  = w;
        for (int t = 0; t < 100; t++) begin
            @(negedge Clk);
            if (in_ready) break;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    // Handshake at edge E0, expect out_valid after E1 (2 cycles from presentation).
    task automatic xfer(input string tag, input logic [17:0] w,
                        input logic [11:0] ed, input logic ec, input logic eu);
        send(w);
        @(negedge Clk); chk({tag, "_lat_early"}, out_valid, 1'b0);
        @(negedge Clk); chk({tag, "_lat_valid"}, out_valid, 1'b1);
        @(posedge Clk); #1;
        chk({tag, "_data"}, last_data, ed);
        chk({tag, "_corr"}, last_corr, ec);
        chk({tag, "_unc"}, last_unc, eu);
    endtask

    task automatic h_xfer(input string tag, input logic [16:0] w, input res_t e);
        h_in_valid = 1'b1;
        h_in_word  = w;
        @(posedge Clk); #1;
        h_in_valid = 1'b0;
        @(negedge Clk); chk({tag, "_lat_early"}, h_out_valid, 1'b0);
        @(negedge Clk); chk({tag, "_lat_valid"}, h_out_valid, 1'b1);
        chk({tag, "_data"}, h_out_data, e.data[11:0]);
        chk({tag, "_corr"}, h_corr, e.corr);
        chk({tag, "_unc"}, h_unc, e.unc);
        @(posedge Clk); #1;
    endtask

    task automatic c_xfer(input string tag, input logic [17:0] w, input res_t e, input logic clr);
        c_in_valid = 1'b1;
        c_in_word  = w;
        @(posedge Clk); #1;
        c_in_valid = 1'b0;
        @(posedge Clk); #1;
        c_clear = clr;
        @(negedge Clk);
        chk({tag, "_valid"}, c_out_valid, 1'b1);
        chk({tag, "_data"}, c_out_data, e.data[11:0]);
        chk({tag, "_corr"}, c_corr, e.corr);
        @(posedge Clk); #1;
        c_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] w;
        logic [16:0] hw;
        logic [31:0] tmp;
        logic        fire;
        int          idx, base;
        logic [17:0] sw [10];

        Reset = 1'b1;
        in_valid = 0; in_word = '0; out_ready = 1; clear_counts = 0;
        h_in_valid = 0; h_in_word = '0; h_out_ready = 1; h_clear = 0;
        c_in_valid = 0; c_in_word = '0; c_out_ready = 1; c_clear = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 12'h000);
        chk("rst_flags", {out_corrected, out_uncorrectable}, 2'b00);
        chk("rst_counts", {corr_count, uncorr_count}, 32'h0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        chk("ready_after_rst", in_ready, 1'b1);

        // ---- directed, default parameters ----
        w = encode(12, 1, 32'hABC);
        xfer("clean", w, 12'hABC, 1'b0, 1'b0);
        xfer("flip_pos5", w ^ (18'd1 << 4), 12'hABC, 1'b1, 1'b0);
        xfer("flip_pos8", w ^ (18'd1 << 7), 12'hABC, 1'b1, 1'b0);
        xfer("flip_overall", w ^ (18'd1 << 17), 12'hABC, 1'b1, 1'b0);
        chk("corr_count_3", corr_count, 16'd3);
        // positions 3 and 10 are data bits 0 and 5
        xfer("double", w ^ (18'd1 << 2) ^ (18'd1 << 9), 12'hA9D, 1'b0, 1'b1);
        chk("uncorr_count_1", uncorr_count, 16'd1);
        chk("corr_count_hold", corr_count, 16'd3);

        // ---- stall: 10 back-to-back words, out_ready low for 5 cycles ----
        for (int i = 0; i < 10; i++) sw[i] = encode(12, 1, $urandom);
        base = out_cnt;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_word = sw[0];
        for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
            @(negedge Clk);
            if (cyc == 3) begin
                chk("stall_accepts", idx, 2);
                chk("stall_in_ready", in_ready, 1'b0);
            end
            fire = in_valid && in_ready;
            @(posedge Clk); #1;
            if (fire) begin
                idx++;
                if (idx < 10) in_word = sw[idx];
                else in_valid = 1'b0;
            end
            if (cyc == 4) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge Clk);
        #1;
        chk("stall_outputs", out_cnt - base, 10);

        // ---- randomized traffic ----
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk);
            fire = in_valid && in_ready;
            @(posedge Clk); #1;
            if (fire || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_word  = rand_word();
            end
            out_ready = ($urandom % 4) != 0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge Clk);
        #1;
        chk("random_drained", exp_q.size(), 0);

        // ---- reset with two words in flight ----
        out_ready = 1'b0;
        send(encode(12, 1, 32'h123));
        send(encode(12, 1, 32'h456));
        Reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_corr_count", corr_count, 16'd0);
        chk("midrst_uncorr_count", uncorr_count, 16'd0);
        exp_q.delete();
        exp_cc = '0;
        exp_uc = '0;
        hold_v = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #1;
        chk("ready_after_midrst", in_ready, 1'b1);
        base = out_cnt;
        xfer("post_rst", encode(12, 1, 32'h5A5), 12'h5A5, 1'b0, 1'b0);
        repeat (5) @(posedge Clk);
        #1;
        chk("post_rst_count", out_cnt - base, 1);

        // ---- SECDED=0 instance ----
        tmp = encode(12, 0, 32'hABC);
        hw = tmp[16:0];
        h_xfer("h_clean", hw, '{data: 32'hABC, corr: 1'b0, unc: 1'b0});
        h_xfer("h_single", hw ^ (17'd1 << 4), '{data: 32'hABC, corr: 1'b1, unc: 1'b0});
        // positions 4 and 16 give syndrome 20, beyond the 17 positions
        h_xfer("h_syn20", hw ^ (17'd1 << 3) ^ (17'd1 << 15), '{data: 32'hABC, corr: 1'b0, unc: 1'b1});
        chk("h_counts", {h_cc, h_uc}, {16'd1, 16'd1});
        for (int i = 0; i < 20; i++) begin
            tmp = encode(12, 0, $urandom);
            tmp[$urandom_range(0, 16)] ^= 1'b1;
            if ($urandom % 2 == 1) tmp[$urandom_range(0, 16)] ^= 1'b1;
            h_xfer("h_rand", tmp[16:0], decode(12, 0, {15'b0, tmp[16:0]}));
        end

        // ---- CNT_W=2 instance: saturation and clear priority ----
        for (int i = 0; i < 5; i++) begin
            tmp = encode(12, 1, $urandom);
            tmp[$urandom_range(0, 17)] ^= 1'b1;
            c_xfer("c_sat", tmp[17:0], decode(12, 1, {14'b0, tmp[17:0]}), 1'b0);
        end
        chk("c_corr_sat", c_cc, 2'd3);
        tmp = encode(12, 1, 32'h321) ^ (32'd1 << 6);
        c_xfer("c_clr", tmp[17:0], '{data: 32'h321, corr: 1'b1, unc: 1'b0}, 1'b1);
        chk("c_corr_cleared", c_cc, 2'd0);
        chk("c_uncorr_zero", c_uc, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
